// File: rtl/qrs_peak_detector.sv
// QRS peak detector: adaptive-threshold beat detection on the averaged
// wavelet multiplier-product stream, with peak tracking and refractory window.
module qrs_peak_detector #(
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          CNT_W      = 16,
    parameter logic [DATA_W-1:0]    INIT_THR   = 32'h0000_1000,
    parameter logic [DATA_W-1:0]    THR_MIN    = 32'h0000_0100,
    parameter int unsigned          REFRACT    = 50,
    parameter int unsigned          MAX_WIDTH  = 40,
    parameter int unsigned          MISS_LIMIT = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mp_valid,
    input  logic [DATA_W-1:0] mp_data,
    output logic              qrs_pulse,
    output logic [DATA_W-1:0] qrs_peak,
    output logic [CNT_W-1:0]  qrs_index,
    output logic [CNT_W-1:0]  rr_interval,
    output logic [DATA_W-1:0] threshold,
    output logic              busy
);

    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int unsigned REF_W  = $clog2(REFRACT + 1);
    localparam int unsigned WID_W  = $clog2(MAX_WIDTH + 1);

    localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MISS_LIMIT - 1);
    localparam logic [REF_W-1:0]  REF_LAST   = REF_W'(REFRACT - 1);
    localparam logic [WID_W-1:0]  WIDTH_LAST = WID_W'(MAX_WIDTH - 1);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_PEAK_TRACK,
        S_REFRACT
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_thr, w_thr_nxt;
    logic [DATA_W-1:0]   r_spk, w_spk_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [MISS_W-1:0]   r_miss, w_miss_nxt;
    logic [REF_W-1:0]    r_ref, w_ref_nxt;
    logic [WID_W-1:0]    r_width, w_width_nxt;
    logic [DATA_W-1:0]   r_pk_val, w_pk_val_nxt;
    logic [CNT_W-1:0]    r_pk_idx, w_pk_idx_nxt;
    logic [CNT_W-1:0]    r_last_idx, w_last_idx_nxt;
    logic                r_first, w_first_nxt;
    logic                r_pulse, w_pulse_nxt;
    logic [DATA_W-1:0]   r_peak, w_peak_nxt;
    logic [CNT_W-1:0]    r_index, w_index_nxt;
    logic [CNT_W-1:0]    r_rr, w_rr_nxt;

    logic                w_pk_upd;
    logic [DATA_W-1:0]   w_pk_eff_val;
    logic [CNT_W-1:0]    w_pk_eff_idx;
    logic [DATA_W:0]     w_spk_sum;
    logic [DATA_W-1:0]   w_spk_decl;
    logic [DATA_W-1:0]   w_thr_decl_raw;
    logic [DATA_W-1:0]   w_thr_decl;
    logic [DATA_W-1:0]   w_thr_half_raw;
    logic [DATA_W-1:0]   w_thr_half;

    // Peak value/index including the current sample, so a declaring sample
    // that is itself larger still lands in the reported peak.
    assign w_pk_upd     = (mp_data > r_pk_val);
    assign w_pk_eff_val = w_pk_upd ? mp_data : r_pk_val;
    assign w_pk_eff_idx = w_pk_upd ? r_cnt   : r_pk_idx;

    // Signal estimate update one bit wider than the data, saturating on overflow.
    assign w_spk_sum      = {1'b0, r_spk}
                          - {4'b0000, r_spk[DATA_W-1:3]}
                          + {4'b0000, w_pk_eff_val[DATA_W-1:3]};
    assign w_spk_decl     = w_spk_sum[DATA_W] ? '1 : w_spk_sum[DATA_W-1:0];
    assign w_thr_decl_raw = w_spk_decl >> 1;
    assign w_thr_decl     = (w_thr_decl_raw < THR_MIN) ? THR_MIN : w_thr_decl_raw;

    assign w_thr_half_raw = r_thr >> 1;
    assign w_thr_half     = (w_thr_half_raw < THR_MIN) ? THR_MIN : w_thr_half_raw;

    always_comb begin
        w_state_nxt    = r_state;
        w_thr_nxt      = r_thr;
        w_spk_nxt      = r_spk;
        w_cnt_nxt      = r_cnt;
        w_miss_nxt     = r_miss;
        w_ref_nxt      = r_ref;
        w_width_nxt    = r_width;
        w_pk_val_nxt   = r_pk_val;
        w_pk_idx_nxt   = r_pk_idx;
        w_last_idx_nxt = r_last_idx;
        w_first_nxt    = r_first;
        w_pulse_nxt    = 1'b0;
        w_peak_nxt     = r_peak;
        w_index_nxt    = r_index;
        w_rr_nxt       = r_rr;

        if (mp_valid) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            unique case (r_state)
                S_SEARCH: begin
                    if (mp_data > r_thr) begin
                        w_state_nxt  = S_PEAK_TRACK;
                        w_pk_val_nxt = mp_data;
                        w_pk_idx_nxt = r_cnt;
                        w_width_nxt  = WID_W'(1);
                    end else if (r_miss == MISS_LAST) begin
                        w_thr_nxt  = w_thr_half;
                        w_spk_nxt  = w_thr_half << 1;
                        w_miss_nxt = '0;
                    end else begin
                        w_miss_nxt = r_miss + MISS_W'(1);
                    end
                end

                S_PEAK_TRACK: begin
                    w_pk_val_nxt = w_pk_eff_val;
                    w_pk_idx_nxt = w_pk_eff_idx;
                    w_width_nxt  = r_width + WID_W'(1);
                    if ((mp_data <= r_thr) || (r_width == WIDTH_LAST)) begin
                        w_pulse_nxt    = 1'b1;
                        w_peak_nxt     = w_pk_eff_val;
                        w_index_nxt    = w_pk_eff_idx;
                        w_rr_nxt       = r_first ? '0 : (w_pk_eff_idx - r_last_idx);
                        w_last_idx_nxt = w_pk_eff_idx;
                        w_first_nxt    = 1'b0;
                        w_spk_nxt      = w_spk_decl;
                        w_thr_nxt      = w_thr_decl;
                        w_ref_nxt      = '0;
                        w_state_nxt    = S_REFRACT;
                    end
                end

                S_REFRACT: begin
                    if (r_ref == REF_LAST) begin
                        w_state_nxt = S_SEARCH;
                        w_miss_nxt  = '0;
                    end else begin
                        w_ref_nxt = r_ref + REF_W'(1);
                    end
                end

                default: begin
                    w_state_nxt = S_SEARCH;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_SEARCH;
            r_thr      <= INIT_THR;
            r_spk      <= INIT_THR << 1;
            r_cnt      <= '0;
            r_miss     <= '0;
            r_ref      <= '0;
            r_width    <= '0;
            r_pk_val   <= '0;
            r_pk_idx   <= '0;
            r_last_idx <= '0;
            r_first    <= 1'b1;
            r_pulse    <= 1'b0;
            r_peak     <= '0;
            r_index    <= '0;
            r_rr       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_thr      <= w_thr_nxt;
            r_spk      <= w_spk_nxt;
            r_cnt      <= w_cnt_nxt;
            r_miss     <= w_miss_nxt;
            r_ref      <= w_ref_nxt;
            r_width    <= w_width_nxt;
            r_pk_val   <= w_pk_val_nxt;
            r_pk_idx   <= w_pk_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_first    <= w_first_nxt;
            r_pulse    <= w_pulse_nxt;
            r_peak     <= w_peak_nxt;
            r_index    <= w_index_nxt;
            r_rr       <= w_rr_nxt;
        end
    end

    assign qrs_pulse   = r_pulse;
    assign qrs_peak    = r_peak;
    assign qrs_index   = r_index;
    assign rr_interval = r_rr;
    assign threshold   = r_thr;
    assign busy        = (r_state != S_SEARCH);

endmodule

// File: tb/tb_qrs_peak_detector.sv
// Directed self-checking bench for qrs_peak_detector: beats, refractory,
// forced width declaration, threshold decay, stalls and mid-peak reset.
module tb_qrs_peak_detector;

    logic        clk;
    logic        rst;
    logic        mp_valid;
    logic [31:0] mp_data;
    logic        qrs_pulse;
    logic [31:0] qrs_peak;
    logic [15:0] qrs_index;
    logic [15:0] rr_interval;
    logic [31:0] threshold;
    logic        busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    qrs_peak_detector #(
        .DATA_W    (32),
        .CNT_W     (16),
        .INIT_THR  (32'h0000_1000),
        .THR_MIN   (32'h0000_0100),
        .REFRACT   (50),
        .MAX_WIDTH (40),
        .MISS_LIMIT(400)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mp_valid   (mp_valid),
        .mp_data    (mp_data),
        .qrs_pulse  (qrs_pulse),
        .qrs_peak   (qrs_peak),
        .qrs_index  (qrs_index),
        .rr_interval(rr_interval),
        .threshold  (threshold),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [31:0] d);
        mp_valid = v;
        mp_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pulse"}, qrs_pulse, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_peak"}, qrs_peak, 0);
        chk({tag, "_index"}, qrs_index, 0);
        chk({tag, "_rr"}, rr_interval, 0);
        chk({tag, "_thr"}, threshold, 32'h1000);
    endtask

    initial begin
        int unsigned npulse;
        int unsigned nbusy;
        logic [31:0] blk_data [5];
        logic [31:0] blk_prev [5];
        logic [31:0] blk_thr  [5];

        rst      = 1'b1;
        mp_valid = 1'b0;
        mp_data  = '0;
        step(0, 0);
        step(0, 0);
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Beat 1: peak 0x4000 at index 1, declared by the 0x800 sample
        step(1, 32'h100);
        chk("b1_idle_busy", busy, 0);
        step(1, 32'h4000);
        chk("b1_track_busy", busy, 1);
        chk("b1_track_nopulse", qrs_pulse, 0);
        step(1, 32'h3000);
        chk("b1_hold_nopulse", qrs_pulse, 0);
        step(1, 32'h800);
        chk("b1_pulse", qrs_pulse, 1);
        chk("b1_peak", qrs_peak, 32'h4000);
        chk("b1_index", qrs_index, 1);
        chk("b1_rr", rr_interval, 0);
        chk("b1_thr", threshold, 32'h1200);
        chk("b1_refract_busy", busy, 1);
        step(1, 32'h100);
        chk("b1_pulse_one_cycle", qrs_pulse, 0);

        // Filler indices 5..100; refractory covers 4..53
        npulse = 0;
        for (int i = 5; i <= 100; i++) begin
            step(1, 32'h100);
            if (qrs_pulse) npulse++;
            if (i == 52) chk("refract_last_busy", busy, 1);
            if (i == 53) chk("refract_exit_busy", busy, 0);
        end
        chk("gap1_nopulse", npulse, 0);

        // Beat 2: peak at index 101; spk 0x2400 -> 0x2780
        step(1, 32'h4000);
        step(1, 32'h3000);
        step(1, 32'h800);
        chk("b2_pulse", qrs_pulse, 1);
        chk("b2_index", qrs_index, 101);
        chk("b2_rr", rr_interval, 100);
        chk("b2_thr", threshold, 32'h13C0);

        // Declared at index 103: 0x8000 at +10 is ignored, at +60 detected
        npulse = 0;
        for (int i = 104; i <= 162; i++) begin
            step(1, (i == 113) ? 32'h8000 : 32'h100);
            if (qrs_pulse) npulse++;
            if (i == 113) chk("refract_ignore_busy", busy, 1);
        end
        chk("refract_ignore_nopulse", npulse, 0);
        step(1, 32'h8000);
        chk("b3_track_busy", busy, 1);
        step(1, 32'h100);
        chk("b3_pulse", qrs_pulse, 1);
        chk("b3_peak", qrs_peak, 32'h8000);
        chk("b3_index", qrs_index, 163);
        chk("b3_rr", rr_interval, 62);
        chk("b3_thr", threshold, 32'h1948);

        // Wide peak from index 221, max 0x7000 at index 241, forced at width 40
        for (int i = 165; i <= 220; i++) step(1, 32'h100);
        npulse = 0;
        for (int k = 0; k < 60; k++) begin
            step(1, (k == 20) ? 32'h7000 : (32'h5000 + 32'(k)));
            if (k == 38) chk("wide_w39_nopulse", qrs_pulse, 0);
            if (k == 39) begin
                chk("wide_pulse", qrs_pulse, 1);
                chk("wide_peak", qrs_peak, 32'h7000);
                chk("wide_index", qrs_index, 241);
                chk("wide_rr", rr_interval, 78);
                chk("wide_thr", threshold, 32'h1D1F);
            end
            if (k >= 40 && qrs_pulse) npulse++;
        end
        chk("wide_after_nopulse", npulse, 0);
        chk("wide_after_busy", busy, 1);

        // Threshold decay: 400 misses per halving, samples equal to threshold miss
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
        chk_reset_outputs("reset2");
        blk_data[0] = 32'h100;  blk_prev[0] = 32'h1000; blk_thr[0] = 32'h800;
        blk_data[1] = 32'h800;  blk_prev[1] = 32'h800;  blk_thr[1] = 32'h400;
        blk_data[2] = 32'h400;  blk_prev[2] = 32'h400;  blk_thr[2] = 32'h200;
        blk_data[3] = 32'h200;  blk_prev[3] = 32'h200;  blk_thr[3] = 32'h100;
        blk_data[4] = 32'h100;  blk_prev[4] = 32'h100;  blk_thr[4] = 32'h100;
        npulse = 0;
        nbusy  = 0;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 400; i++) begin
                step(1, blk_data[b]);
                if (qrs_pulse) npulse++;
                if (busy) nbusy++;
                if (i == 398) chk($sformatf("decay%0d_before", b), threshold, blk_prev[b]);
            end
            chk($sformatf("decay%0d_after", b), threshold, blk_thr[b]);
        end
        chk("decay_nopulse", npulse, 0);
        chk("decay_equal_nobusy", nbusy, 0);

        // At the floor: 0x200 starts, 0x100 (== threshold) ends the peak
        step(1, 32'h200);
        chk("floor_track_busy", busy, 1);
        step(1, 32'h100);
        chk("floor_pulse", qrs_pulse, 1);
        chk("floor_peak", qrs_peak, 32'h200);
        chk("floor_index", qrs_index, 2000);
        chk("floor_rr_first", rr_interval, 0);
        chk("floor_thr", threshold, 32'h100);

        // Stall mid-peak, then reset during PEAK_TRACK
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
        step(1, 32'h2000);
        chk("stall_track_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 32'h800);
            chk("stall_nopulse", qrs_pulse, 0);
            chk("stall_busy", busy, 1);
        end
        step(1, 32'h3000);
        chk("stall_resume_nopulse", qrs_pulse, 0);
        rst = 1'b1;
        step(1, 32'h100);
        rst = 1'b0;
        chk_reset_outputs("midpeak_rst");
        step(1, 32'h3000);
        chk("post_rst_busy", busy, 1);
        step(1, 32'h100);
        chk("post_rst_pulse", qrs_pulse, 1);
        chk("post_rst_peak", qrs_peak, 32'h3000);
        chk("post_rst_index", qrs_index, 0);
        chk("post_rst_rr", rr_interval, 0);
        chk("post_rst_thr", threshold, 32'h1100);
        step(0, 0);
        chk("stall_clears_pulse", qrs_pulse, 0);
        chk("stall_keeps_peak", qrs_peak, 32'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
